// File: rtl/nf_rf_wb_pkg.sv
// nf_rf_wb_pkg: shared defaults, FIFO entry type and hazard helper for the
// register-file writeback controller.
package nf_rf_wb_pkg;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

    // A busy source is not a hazard when the same register is being written this cycle.
    function automatic logic src_hazard(input logic [4:0] a, input logic [31:0] busy,
                                        input logic pop, input logic [4:0] pop_addr);
        return (a != 5'd0) && busy[a] && !(pop && (a == pop_addr));
    endfunction
endpackage

// File: rtl/nf_rf_wb_fifo.sv
// nf_rf_wb_fifo: load-return buffer; pointers wrap naturally at a power-of-two depth.
module nf_rf_wb_fifo
    import nf_rf_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  rf_wr_t din,
    output logic   full,
    output logic   empty,
    output rf_wr_t head
);
    localparam int AW = $clog2(DEPTH);

    rf_wr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/nf_rf_wb_ctrl.sv
// nf_rf_wb_ctrl: arbitrates the register-file write port between pipeline writeback
// and buffered load returns, with starvation drain and a busy-register scoreboard.
module nf_rf_wb_ctrl
    import nf_rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_req,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ld_vld,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_rdy,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_addr,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  rd_dec,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic        stall
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic           full;
    logic           empty;
    logic           pop;
    logic           pipe;
    logic           starve;
    logic           hazard;
    rf_wr_t         head;
    rf_wr_t         grant;
    logic [SW-1:0]  starve_cnt;
    logic [31:0]    busy;
    logic [31:0]    set_mask;
    logic [31:0]    clr_mask;

    nf_rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_vld & ld_rdy),
        .pop   (pop),
        .din   ({ld_addr, ld_data}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Outputs are gated with rst so nothing is granted or accepted while reset is held.
    assign ld_rdy   = ~full & ~rst;
    assign starve   = starve_cnt == SW'(STARVE_MAX);
    assign pop      = ~rst & ~empty & (starve | ~wb_req);
    assign pipe     = ~rst & wb_req & ~pop;
    assign grant    = pop ? head : pipe ? rf_wr_t'({wb_addr, wb_data}) : rf_wr_t'('0);
    assign wa3      = grant.addr;
    assign wd3      = grant.data;
    assign we3      = (pop | pipe) & (grant.addr != 5'd0);
    assign hazard   = src_hazard(ra1, busy, pop, head.addr) | src_hazard(ra2, busy, pop, head.addr)
                    | src_hazard(rd_dec, busy, pop, head.addr);
    assign stall    = hazard | starve;
    assign set_mask = (ld_issue && ld_issue_addr != 5'd0) ? 32'd1 << ld_issue_addr : 32'd0;
    assign clr_mask = pop ? 32'd1 << head.addr : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            starve_cnt <= pop ? '0 : (pipe && !empty && !starve) ? starve_cnt + 1'b1 : starve_cnt;
            busy       <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end
endmodule
